// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin arbiter that shares one 8-digit
// seven-segment display path among NREQ requesters, with a minimum hold.
// Ports: clk, nrst (async active-low), req[NREQ], req_digits, req_flt_pt in;
//        digits, flt_pt (registered), grant (one-hot), grant_id, busy out.
// Option: define SEG_ARB_PREEMPT_EN to make requester 0 a preempting
//         high-priority source; undefined gives pure round-robin.
module seg_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 100
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0][7:0][3:0]       req_digits,
    input  logic [NREQ-1:0][7:0]            req_flt_pt,
    output logic [7:0][3:0]                 digits,
    output logic [7:0]                      flt_pt,
    output logic [NREQ-1:0]                 grant,
    output logic [$clog2(NREQ)-1:0]         grant_id,
    output logic                            busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_EXP = CW'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      gid_q, gid_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0][3:0]     digits_q, digits_d;
    logic [7:0]          flt_q, flt_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                expired;
    logic [IDW-1:0]      pick;
    logic [CW-1:0]       cnt_inc;

    // First requester found walking last+1, last+2, ... and wrapping; the
    // previous grantee is examined last. Returns 'last' when nobody asks.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IDW-1:0]  last
    );
        int idx;
        rr_pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (r[idx]) rr_pick = IDW'(idx);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        expired = (cnt_q >= HOLD_EXP);
        pick    = rr_pick(req, gid_q);
        cnt_inc = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gid_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!expired) begin
                    cnt_d = cnt_inc;
                end else if (!(|req)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pick != gid_q) begin
                    gid_d = pick;
                    cnt_d = '0;
                end else begin
                    // Only the current grantee still asks: keep it.
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SEG_ARB_PREEMPT_EN
        // Requester 0 overrides the hold counter and keeps the grant
        // for as long as it keeps asking.
        if (req[0]) begin
            state_d = GRANT;
            gid_d   = '0;
            if (state_q == GRANT && gid_q == '0) cnt_d = cnt_inc;
            else                                 cnt_d = '0;
        end
`endif

        // Data follows the grantee of the coming cycle, so a new grant
        // and its data appear together.
        digits_d = digits_q;
        flt_d    = flt_q;
        grant_d  = '0;
        busy_d   = (state_d == GRANT);
        if (state_d == GRANT) begin
            digits_d       = req_digits[gid_d];
            flt_d          = req_flt_pt[gid_d];
            grant_d[gid_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            gid_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            flt_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            flt_q    <= flt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign digits   = digits_q;
    assign flt_pt   = flt_q;
    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: vector table, directed sequences and random
// traffic for seg_display_arbiter (NREQ=4, HOLD_CYCLES=4).
module tb_seg_display_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    logic                      clk = 1'b0;
    logic                      nrst = 1'b0;
    logic [NREQ-1:0]           req = '0;
    logic [NREQ-1:0][7:0][3:0] req_digits = '0;
    logic [NREQ-1:0][7:0]      req_flt_pt = '0;
    logic [7:0][3:0]           digits;
    logic [7:0]                flt_pt;
    logic [NREQ-1:0]           grant;
    logic [1:0]                grant_id;
    logic                      busy;

    seg_display_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req        (req),
        .req_digits (req_digits),
        .req_flt_pt (req_flt_pt),
        .digits     (digits),
        .flt_pt     (flt_pt),
        .grant      (grant),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference: who owns the display, for how many cycles, and what
    // was last shown.
    int          m_owner;
    int          m_last;
    int          m_age;
    logic [31:0] m_dig;
    logic [7:0]  m_flt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] dut_vec();
        return {17'd0, grant, grant_id, busy, flt_pt, digits};
    endfunction

    function automatic logic [63:0] model_vec();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        return {17'd0, g, 2'(m_last), (m_owner >= 0), m_flt, m_dig};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_age   = 0;
        m_dig   = '0;
        m_flt   = '0;
    endtask

    // First requester after m_last in circular order, skipping 'skip'.
    function automatic int next_req(input logic [3:0] r, input int skip);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (r[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic model_update();
        int w;
        logic done;
        done = 1'b0;
`ifdef SEG_ARB_PREEMPT_EN
        if (req[0]) begin
            if (m_owner == 0) m_age++;
            else begin
                m_owner = 0;
                m_age   = 1;
            end
            done = 1'b1;
        end
`endif
        if (!done) begin
            if (m_owner < 0) begin
                w = next_req(req, -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_age   = 1;
                end
            end else if (m_age < HOLD) begin
                m_age++;
            end else begin
                w = next_req(req, m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_age   = 1;
                end else if (req[m_owner]) m_age++;
                else m_owner = -1;
            end
        end
        if (m_owner >= 0) begin
            m_last = m_owner;
            m_dig  = req_digits[m_owner];
            m_flt  = req_flt_pt[m_owner];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_digits[i] = $urandom;
            req_flt_pt[i] = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        req = 4'($urandom);
        rand_data();
        #1;
        chk("rst_async", dut_vec(), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold", dut_vec(), 64'd0);
        req  = '0;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", dut_vec(), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] d2;
        logic [3:0]  g;
        logic [1:0]  id;
        logic        b;
        logic [31:0] dig;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{4'b0100, 32'hBADBAD00, 4'b0100, 2'd2, 1'b1, 32'hBADBAD00};
        tbl[1] = '{4'b0000, 32'h12345678, 4'b0100, 2'd2, 1'b1, 32'h12345678};
        tbl[2] = '{4'b0000, 32'h12345678, 4'b0100, 2'd2, 1'b1, 32'h12345678};
        tbl[3] = '{4'b0000, 32'hCAFEF00D, 4'b0100, 2'd2, 1'b1, 32'hCAFEF00D};
        tbl[4] = '{4'b0000, 32'h55555555, 4'b0000, 2'd2, 1'b0, 32'hCAFEF00D};
        tbl[5] = '{4'b0000, 32'h66666666, 4'b0000, 2'd2, 1'b0, 32'hCAFEF00D};
        tbl[6] = '{4'b0001, 32'h77777777, 4'b0001, 2'd0, 1'b1, 32'h00000000};

        model_reset();
        do_reset();

        // Single request, data follow, hold then release.
        req_digits = '0;
        req_flt_pt = '0;
        for (int i = 0; i < 7; i++) begin
            req = tbl[i].req;
            req_digits[2] = tbl[i].d2;
            step();
            chk($sformatf("tbl%0d", i),
                {27'd0, grant, grant_id, busy, digits},
                {27'd0, tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].dig});
        end

        // Round-robin with all four requesting.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_digits[i] = 32'h11111111 * (i + 1);
            req_flt_pt[i] = 8'(1 << i);
        end
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            int e;
`ifdef SEG_ARB_PREEMPT_EN
            e = 0;
`else
            e = (1 + c / HOLD) % NREQ;
`endif
            step();
            chk($sformatf("rr%0d", c),
                {22'd0, grant, grant_id, busy, digits},
                {22'd0, 4'(1 << e), 2'(e), 1'b1, 32'h11111111 * (e + 1)});
        end

        // Simultaneous requests, then async reset in the 2nd grant cycle.
        do_reset();
        req = 4'b1001;
        step();
`ifdef SEG_ARB_PREEMPT_EN
        chk("simul_id", 64'(grant_id), 64'd0);
`else
        chk("simul_id", 64'(grant_id), 64'd3);
`endif
        step();
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst", dut_vec(), 64'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        req  = '0;

        // Requester 2 granted, then requester 0 arrives.
        do_reset();
        req = 4'b0100;
        step();
        chk("pre_g2", 64'(grant_id), 64'd2);
        req = 4'b0001;
        step();
`ifdef SEG_ARB_PREEMPT_EN
        chk("pre_sw0", 64'(grant), 64'b0001);
`else
        chk("pre_sw0", 64'(grant), 64'b0100);
`endif
        req = 4'b1001;
        step();
        req = 4'b1000;
        for (int c = 0; c < 5; c++) step();
        chk("pre_to3", 64'(grant), 64'b1000);

        // Random traffic against the reference.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 9) == 0) req = '0;
            rand_data();
            step();
            if (c == 200) begin
                #2;
                nrst = 1'b0;
                model_reset();
                #1;
                chk("rand_rst", dut_vec(), 64'd0);
                @(posedge clk);
                #1;
                nrst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the single 8-digit seven-segment display path among up to NREQ independent requesters, such as the game core, a debug monitor and a score/timer unit. Sits directly upstream of the seven_seg decoder and drives its `digits` and `flt_pt` inputs. Uses round-robin arbitration with a guaranteed minimum hold time per grant, so every displayed value stays readable. Outputs are registered and hold their last value while no one is granted.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `HOLD_CYCLES`, 100, minimum number of cycles a grant persists (>= 1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request per requester; level-sensitive.
- `req_digits`  in  [NREQ-1:0][7:0][3:0]  per-requester hex digits; digit 7 is leftmost.
- `req_flt_pt`  in  [NREQ-1:0][7:0]  per-requester decimal-point bits.
- `digits`  out  [7:0][3:0]  registered digits to the decoder.
- `flt_pt`  out  [7:0]  registered decimal points to the decoder.
- `grant`  out  NREQ  one-hot grant; all-zero when idle.
- `grant_id`  out  $clog2(NREQ)  index of the current or most recent grantee.
- `busy`  out  1  high while in the GRANT state.

## Operation
**States**
- IDLE: `grant` = 0, `busy` = 0; `digits` and `flt_pt` hold their last value.
- GRANT: `grant[g]` = 1; `digits`/`flt_pt` are loaded every cycle from `req_digits[g]`/`req_flt_pt[g]`, whether or not `req[g]` is still high.

**Arbitration (round-robin)**
- Search order starts at index `grant_id`+1 (mod NREQ) and wraps.
- The most recent grantee is therefore lowest priority.
- After reset `grant_id` = 0, so the first search order is 1, 2, …, NREQ-1, 0.

**Hold counter**
- Width is $clog2(HOLD_CYCLES+1).
- Cleared to 0 on every new grant, including a switch from GRANT directly to GRANT.
- Increments each GRANT cycle and saturates at HOLD_CYCLES.
- The grant has expired when the counter is >= HOLD_CYCLES-1.

**Transitions**
- IDLE: any `req` bit high → GRANT to the round-robin winner.
- GRANT, not expired: stay, even if `req[g]` has dropped.
- GRANT, expired, another requester pending → GRANT to the next round-robin winner; no idle cycle in between.
- GRANT, expired, only `req[g]` high → stay; counter saturates.
- GRANT, expired, no `req` bits high → IDLE.

**Reset values**
- `digits` = 0, `flt_pt` = 0, `grant` = 0, `grant_id` = 0, `busy` = 0, counter = 0, state = IDLE.
- Asserting `nrst` mid-grant aborts immediately to these values.

**Invariant:** `grant` is always one-hot or zero and always consistent with `grant_id` and `busy`.

## Timing
- A `req` sampled high at edge N while IDLE gives `grant`/`busy` high and `digits` = `req_digits[winner]` (as sampled at edge N) after edge N.
- The data path is a single register stage: an input change is visible one cycle later.
- A grant lasts at least HOLD_CYCLES cycles.
- On a switch, the new grantee's data appears in the same cycle as its `grant` bit.
- Requests that rise and fall while another requester holds the grant are lost; there is no request latching.
- When several `req` bits rise on the same edge in IDLE, the round-robin order decides a single winner.

## Configuration
- `SEG_ARB_PREEMPT_EN` defined:
  - Requester 0 is high priority.
  - When `req[0]` is high and the current grantee is not 0, the arbiter switches to 0 on the next edge, ignoring the hold counter, which is cleared.
  - While granted, requester 0 keeps the grant as long as `req[0]` is high, even after expiry.
  - When requester 0 releases, arbitration resumes round-robin from index 1.
- `SEG_ARB_PREEMPT_EN` undefined: pure round-robin for all requesters, including 0; no preemption logic is synthesized.

## Test plan
All scenarios use NREQ = 4, HOLD_CYCLES = 4.
- **Reset:** drive `nrst` low with random inputs → all outputs 0. Release with `req` = 0 → outputs stay 0 and `busy` = 0.
- **Single request:** `req` = 0b0100, `req_digits[2]` = 0xBADBAD00 → next cycle `grant` = 0b0100, `grant_id` = 2, `digits` = 0xBADBAD00. Change the input to 0x12345678 → the output follows one cycle later.
- **Hold then release:** `req[2]` pulses for 1 cycle → grant persists exactly 4 cycles, then IDLE. `digits` stays at the last value and `grant` = 0.
- **Round-robin:** `req` = 0b1111 held → grant sequence 1, 2, 3, 0, 1, each lasting exactly 4 cycles with no idle gaps.
- **Simultaneous and mid-grant reset:** from reset, `req` = 0b1001 on the same edge → grant goes to 3. Assert `nrst` on the 2nd grant cycle → everything returns to reset values asynchronously.
- **Preempt** (`SEG_ARB_PREEMPT_EN` defined): requester 2 is granted; raise `req[0]` on the 1st hold cycle → grant moves to 0 on the next edge. Drop `req[0]` with `req[3]` pending → grant moves to 3. With the macro undefined, requester 2 keeps its full 4 cycles.
